// File: rtl/info_frame_pkg.sv
// Shared types, constants and helpers for the HDMI InfoFrame packetizer.
// info_checksum() yields PB0 so that header + PB0..PB(len) sums to zero mod 256.
package info_frame_pkg;

    typedef logic [7:0] pb_t;

    localparam int INFO_PB_MAX = 27;
    localparam int SUB_W       = 56;
    localparam int HEADER_W    = 24;

    localparam logic [6:0] INFO_TYPE_AVI   = 7'd2;
    localparam logic [6:0] INFO_TYPE_SPD   = 7'd3;
    localparam logic [6:0] INFO_TYPE_AUDIO = 7'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SUM    = 2'd1,
        ST_COMMIT = 2'd2
    } info_state_t;

    function automatic logic [215:0] info_mask(input logic [215:0] pb, input int len);
        logic [215:0] m;
        m = pb;
        for (int k = 1; k <= INFO_PB_MAX; k++) begin
            if (k > len) begin
                m[8*k-1 -: 8] = 8'h00;
            end
        end
        return m;
    endfunction

    function automatic pb_t info_checksum(input logic [23:0] header, input logic [215:0] pb,
                                          input int len);
        pb_t s;
        s = header[7:0] + header[15:8] + header[23:16];
        for (int k = 1; k <= INFO_PB_MAX; k++) begin
            if (k <= len) begin
                s = s + pb[8*k-1 -: 8];
            end
        end
        return (~s) + 8'd1;
    endfunction

endpackage

// File: rtl/info_frame_checksum.sv
// Serial 8-bit InfoFrame checksum: load the header sum on start, absorb one byte per
// byte_valid, present the two's complement of the running sum.
module info_frame_checksum
    import info_frame_pkg::*;
#(
    parameter logic [4:0] LEN = 5'd10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_init,
    input  logic       i_byte_valid,
    input  logic [7:0] i_byte,
    output logic [4:0] o_count,
    output logic       o_done,
    output logic [7:0] o_checksum
);

    pb_t        r_acc;
    logic [4:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc   <= 8'h00;
            r_count <= 5'd0;
        end else if (i_start) begin
            r_acc   <= i_init;
            r_count <= 5'd0;
        end else if (i_byte_valid) begin
            r_acc   <= r_acc + i_byte;
            r_count <= r_count + 5'd1;
        end
    end

    // o_done flags the cycle that absorbs the final payload byte
    assign o_count    = r_count;
    assign o_done     = i_byte_valid && (r_count == LEN - 5'd1);
    assign o_checksum = (~r_acc) + 8'd1;

endmodule

// File: rtl/info_frame_packetizer.sv
// Runtime-configurable HDMI InfoFrame source in the clk_pixel domain.
// Define INFO_FRAME_RESET_VALID_EN to come out of reset with a valid DEFAULT_PB packet.
module info_frame_packetizer
    import info_frame_pkg::*;
#(
    parameter logic [6:0]   INFO_TYPE     = INFO_TYPE_AUDIO,
    parameter logic [7:0]   INFO_VERSION  = 8'd1,
    parameter logic [4:0]   INFO_LENGTH   = 5'd10,
    parameter int           REPEAT_FRAMES = 1,
    parameter logic [215:0] DEFAULT_PB    = '0
) (
    input  logic         clk_pixel,
    input  logic         reset_n,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [215:0] cfg_pb,
    input  logic         frame_start,
    output logic         pkt_valid,
    input  logic         pkt_ready,
    output logic [23:0]  header,
    output logic [223:0] sub,
    output logic         overrun
);

    localparam logic [23:0] HEADER     = {3'b000, INFO_LENGTH, INFO_VERSION, 1'b1, INFO_TYPE};
    localparam pb_t         HEADER_SUM = HEADER[7:0] + HEADER[15:8] + HEADER[23:16];
    localparam int          CNT_W      = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_FRAMES - 1);
`ifdef INFO_FRAME_RESET_VALID_EN
    localparam logic [223:0] RESET_SUB = {info_mask(DEFAULT_PB, int'(INFO_LENGTH)),
                                          info_checksum(HEADER, DEFAULT_PB, int'(INFO_LENGTH))};
    localparam logic         RESET_SHADOW_VALID = 1'b1;
`else
    localparam logic [223:0] RESET_SUB = '0;
    localparam logic         RESET_SHADOW_VALID = 1'b0;
`endif

    info_state_t      r_state;
    info_state_t      w_next_state;
    logic [215:0]     r_stage;
    logic [223:0]     r_sub;
    logic             r_shadow_valid;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_pkt_valid;
    logic             r_overrun;

    logic             w_start;
    logic             w_byte_valid;
    logic             w_commit;
    logic             w_slot;
    logic [7:0]       w_sum_byte;
    logic [4:0]       w_count;
    logic             w_done;
    logic [7:0]       w_checksum;

    info_frame_checksum #(
        .LEN (INFO_LENGTH)
    ) u_checksum (
        .i_clk        (clk_pixel),
        .i_rst_n      (reset_n),
        .i_start      (w_start),
        .i_init       (HEADER_SUM),
        .i_byte_valid (w_byte_valid),
        .i_byte       (w_sum_byte),
        .o_count      (w_count),
        .o_done       (w_done),
        .o_checksum   (w_checksum)
    );

    // Byte k of staging (counting from 0) is PB(k+1)
    assign w_sum_byte = r_stage[{w_count, 3'b000} +: 8];

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_byte_valid = 1'b0;
        w_commit     = 1'b0;
        cfg_ready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    w_start      = 1'b1;
                    w_next_state = ST_SUM;
                end
            end
            ST_SUM: begin
                w_byte_valid = 1'b1;
                if (w_done) begin
                    w_next_state = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // Hold the new packet back while the picker still owns the current one
                if (!r_pkt_valid || pkt_ready) begin
                    w_commit     = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_stage <= '0;
        end else if (w_start) begin
            r_stage <= info_mask(cfg_pb, int'(INFO_LENGTH));
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_sub          <= RESET_SUB;
            r_shadow_valid <= RESET_SHADOW_VALID;
        end else if (w_commit) begin
            r_sub          <= {r_stage, w_checksum};
            r_shadow_valid <= 1'b1;
        end
    end

    assign w_slot = frame_start && (r_frame_cnt == '0) && r_shadow_valid;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= '0;
        end else if (frame_start) begin
            r_frame_cnt <= (r_frame_cnt == CNT_LAST) ? '0 : r_frame_cnt + CNT_W'(1);
        end
    end

    // A slot never queues a second packet; it re-offers or flags overrun instead
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= w_slot && r_pkt_valid && !pkt_ready;
            if (w_slot) begin
                r_pkt_valid <= 1'b1;
            end else if (r_pkt_valid && pkt_ready) begin
                r_pkt_valid <= 1'b0;
            end
        end
    end

    assign header    = HEADER;
    assign sub       = r_sub;
    assign pkt_valid = r_pkt_valid;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_info_frame_packetizer.sv
// Self-checking bench for info_frame_packetizer (audio frame, length 10, one packet per 2 frames).
// Expected packets come from a plain-arithmetic model of the InfoFrame checksum rule.
module tb_info_frame_packetizer;

    localparam int          LEN    = 10;
    localparam int          REPEAT = 2;
    localparam logic [23:0] HDR    = 24'h0A0184;

    logic         clk_pixel = 1'b0;
    logic         reset_n;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [215:0] cfg_pb;
    logic         frame_start;
    logic         pkt_valid;
    logic         pkt_ready;
    logic [23:0]  header;
    logic [223:0] sub;
    logic         overrun;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [223:0] exp_sub;
    logic         exp_valid;
    int           fcount;

    info_frame_packetizer #(
        .INFO_TYPE     (7'd4),
        .INFO_VERSION  (8'd1),
        .INFO_LENGTH   (5'd10),
        .REPEAT_FRAMES (REPEAT)
    ) dut (
        .clk_pixel   (clk_pixel),
        .reset_n     (reset_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pb      (cfg_pb),
        .frame_start (frame_start),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .header      (header),
        .sub         (sub),
        .overrun     (overrun)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Packet image: PB1..PB(LEN) copied, the rest zero, PB0 makes the byte sum zero
    function automatic logic [223:0] model_packet(input logic [215:0] pb);
        logic [223:0] p;
        int           sum;
        p   = '0;
        sum = 'h84 + 'h01 + LEN;
        for (int k = 1; k <= 27; k++) begin
            if (k <= LEN) begin
                p[8*k+7 -: 8] = pb[8*k-1 -: 8];
                sum += int'(pb[8*k-1 -: 8]);
            end
        end
        p[7:0] = 8'((256 - (sum % 256)) % 256);
        return p;
    endfunction

    function automatic logic [215:0] random_pb();
        logic [215:0] pb;
        for (int k = 0; k < 27; k++) begin
            pb[8*k +: 8] = 8'($urandom_range(0, 255));
        end
        return pb;
    endfunction

    task automatic model_reset();
`ifdef INFO_FRAME_RESET_VALID_EN
        exp_sub   = model_packet('0);
        exp_valid = 1'b1;
`else
        exp_sub   = '0;
        exp_valid = 1'b0;
`endif
        fcount = 0;
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge
    task automatic send_cfg(input logic [215:0] pb);
        int waited;
        waited = 0;
        while (cfg_ready !== 1'b1 && waited < 64) begin
            @(negedge clk_pixel);
            waited++;
        end
        n_checks++;
        if (cfg_ready !== 1'b1) $display("[TB] FAIL cfg_ready_timeout: cfg_ready=%b required 1", cfg_ready);
        else n_pass++;
        cfg_valid = 1'b1;
        cfg_pb    = pb;
        @(negedge clk_pixel);
        cfg_valid = 1'b0;
    endtask

    task automatic frame_pulse(output bit slot);
        slot   = (fcount == 0) && exp_valid;
        fcount = (fcount + 1) % REPEAT;
        frame_start = 1'b1;
        @(negedge clk_pixel);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_pixel);
        n_checks++;
        if (cfg_ready !== 1'b1) $display("[TB] FAIL reset_cfg_ready: got %b expected 1", cfg_ready); else n_pass++;
        n_checks++;
        if (pkt_valid !== 1'b0) $display("[TB] FAIL reset_pkt_valid: got %b expected 0", pkt_valid); else n_pass++;
        n_checks++;
        if (overrun !== 1'b0) $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); else n_pass++;
        n_checks++;
        if (sub !== exp_sub) $display("[TB] FAIL reset_sub: got %h expected %h", sub, exp_sub); else n_pass++;
        n_checks++;
        if (header !== HDR) $display("[TB] FAIL header: got %h expected %h", header, HDR); else n_pass++;
        reset_n = 1'b1;
        @(negedge clk_pixel);
    endtask

    task automatic test_audio();
        logic [215:0] pb;
        logic [223:0] want;
        pb        = '0;
        pb[7:0]   = 8'h01;
        want      = model_packet(pb);
        pkt_ready = 1'b0;
        send_cfg(pb);
        n_checks++;
        if (cfg_ready !== 1'b0) $display("[TB] FAIL sum_cfg_ready: got %b expected 0", cfg_ready); else n_pass++;
        repeat (LEN) @(negedge clk_pixel);
        n_checks++;
        if (sub !== exp_sub) $display("[TB] FAIL audio_early: got %h expected %h", sub, exp_sub); else n_pass++;
        @(negedge clk_pixel);
        n_checks++;
        if (sub !== want) $display("[TB] FAIL audio_sub: got %h expected %h", sub, want); else n_pass++;
        n_checks++;
        if (sub[15:0] !== 16'h0170) $display("[TB] FAIL audio_pb0_pb1: got %h expected 0170", sub[15:0]); else n_pass++;
        n_checks++;
        if (cfg_ready !== 1'b1) $display("[TB] FAIL audio_idle: got %b expected 1", cfg_ready); else n_pass++;
        exp_sub   = want;
        exp_valid = 1'b1;
    endtask

    task automatic test_mask();
        logic [223:0] want;
        want = model_packet({216{1'b1}});
        send_cfg({216{1'b1}});
        repeat (LEN + 1) @(negedge clk_pixel);
        n_checks++;
        if (sub !== want) $display("[TB] FAIL mask_sub: got %h expected %h", sub, want); else n_pass++;
        n_checks++;
        if (sub[223:88] !== '0) $display("[TB] FAIL mask_upper: got %h expected 0", sub[223:88]); else n_pass++;
        // 0x8F + 10*0xFF = 0x85 mod 256, negated gives 0x7B
        n_checks++;
        if (sub[7:0] !== 8'h7B) $display("[TB] FAIL mask_pb0: got %h expected 7b", sub[7:0]); else n_pass++;
        exp_sub = want;
    endtask

    task automatic test_repeat();
        int  slots, highs, rises, ovrs, bad_sub;
        bit  slot, prev;
        slots = 0; highs = 0; rises = 0; ovrs = 0; bad_sub = 0; prev = 1'b0;
        pkt_ready = 1'b1;
        for (int p = 0; p < 6; p++) begin
            frame_pulse(slot);
            if (slot) slots++;
            for (int c = 0; c < 4; c++) begin
                if (c > 0) @(negedge clk_pixel);
                if (pkt_valid === 1'b1) begin
                    highs++;
                    if (!prev) rises++;
                    if (sub !== exp_sub) bad_sub++;
                end
                if (overrun === 1'b1) ovrs++;
                prev = (pkt_valid === 1'b1);
            end
        end
        n_checks++;
        if (highs !== slots) $display("[TB] FAIL repeat_valid_cycles: got %0d expected %0d", highs, slots); else n_pass++;
        n_checks++;
        if (rises !== 3) $display("[TB] FAIL repeat_pulses: got %0d expected 3", rises); else n_pass++;
        n_checks++;
        if (ovrs !== 0 || bad_sub !== 0) $display("[TB] FAIL repeat_clean: overrun=%0d bad_sub=%0d expected 0/0", ovrs, bad_sub); else n_pass++;
    endtask

    task automatic test_overrun();
        int  exp_ovr, ovrs, drops, changes;
        bit  slot, mvalid;
        logic [223:0] held;
        exp_ovr = 0; ovrs = 0; drops = 0; changes = 0; mvalid = 1'b0;
        pkt_ready = 1'b0;
        held = exp_sub;
        for (int p = 0; p < 6; p++) begin
            frame_pulse(slot);
            if (slot) begin
                if (mvalid) exp_ovr++;
                mvalid = 1'b1;
            end
            for (int c = 0; c < 4; c++) begin
                if (c > 0) @(negedge clk_pixel);
                if (overrun === 1'b1) ovrs++;
                if (mvalid && pkt_valid !== 1'b1) drops++;
                if (sub !== held) changes++;
            end
        end
        n_checks++;
        if (ovrs !== exp_ovr) $display("[TB] FAIL overrun_count: got %0d expected %0d", ovrs, exp_ovr); else n_pass++;
        n_checks++;
        if (drops !== 0) $display("[TB] FAIL overrun_valid_drop: got %0d expected 0", drops); else n_pass++;
        n_checks++;
        if (changes !== 0) $display("[TB] FAIL overrun_sub_stable: got %0d expected 0", changes); else n_pass++;
    endtask

    task automatic test_commit_hold();
        logic [215:0] pb;
        logic [223:0] want;
        bit           slot;
        int           guard;
        pb   = random_pb();
        want = model_packet(pb);
        send_cfg(pb);
        repeat (LEN + 6) @(negedge clk_pixel);
        n_checks++;
        if (sub !== exp_sub) $display("[TB] FAIL hold_sub: got %h expected %h", sub, exp_sub); else n_pass++;
        n_checks++;
        if (cfg_ready !== 1'b0 || pkt_valid !== 1'b1) $display("[TB] FAIL hold_state: cfg_ready=%b pkt_valid=%b expected 0/1", cfg_ready, pkt_valid); else n_pass++;
        pkt_ready = 1'b1;
        @(negedge clk_pixel);
        pkt_ready = 1'b0;
        n_checks++;
        if (sub !== want) $display("[TB] FAIL hold_commit_sub: got %h expected %h", sub, want); else n_pass++;
        n_checks++;
        if (pkt_valid !== 1'b0 || cfg_ready !== 1'b1) $display("[TB] FAIL hold_release: pkt_valid=%b cfg_ready=%b expected 0/1", pkt_valid, cfg_ready); else n_pass++;
        exp_sub = want;
        slot = 1'b0; guard = 0;
        while (!slot && guard < REPEAT) begin
            frame_pulse(slot);
            guard++;
        end
        n_checks++;
        if (pkt_valid !== 1'b1 || sub !== want) $display("[TB] FAIL hold_next_packet: pkt_valid=%b sub=%h expected 1/%h", pkt_valid, sub, want); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit slot;
        int guard;
        guard = 0;
        pkt_ready = 1'b0;
        while (!((fcount == 0) && exp_valid) && guard < REPEAT) begin
            frame_pulse(slot);
            guard++;
        end
        pkt_ready = 1'b1;
        frame_pulse(slot);
        n_checks++;
        if (pkt_valid !== 1'b1 || overrun !== 1'b0) $display("[TB] FAIL b2b_reoffer: pkt_valid=%b overrun=%b expected 1/0", pkt_valid, overrun); else n_pass++;
        @(negedge clk_pixel);
        pkt_ready = 1'b0;
        n_checks++;
        if (pkt_valid !== 1'b0) $display("[TB] FAIL b2b_drop: got %b expected 0", pkt_valid); else n_pass++;
    endtask

    task automatic test_random();
        logic [215:0] pb;
        logic [223:0] want;
        logic [7:0]   s;
        pkt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pb   = random_pb();
            want = model_packet(pb);
            send_cfg(pb);
            repeat (LEN + 1) @(negedge clk_pixel);
            n_checks++;
            if (sub !== want) $display("[TB] FAIL random_sub_%0d: got %h expected %h", i, sub, want); else n_pass++;
            s = 8'h84 + 8'h01 + 8'(LEN);
            for (int k = 0; k <= LEN; k++) s = s + sub[8*k +: 8];
            n_checks++;
            if (s !== 8'h00) $display("[TB] FAIL random_bytesum_%0d: got %h expected 00", i, s); else n_pass++;
            exp_sub = want;
        end
    endtask

    task automatic test_reset_mid();
        bit slot;
        pkt_ready = 1'b0;
        send_cfg(random_pb());
        repeat (4) @(negedge clk_pixel);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (cfg_ready !== 1'b1 || pkt_valid !== 1'b0 || overrun !== 1'b0) $display("[TB] FAIL midreset_ctrl: cfg_ready=%b pkt_valid=%b overrun=%b expected 1/0/0", cfg_ready, pkt_valid, overrun); else n_pass++;
        n_checks++;
        if (sub !== exp_sub) $display("[TB] FAIL midreset_sub: got %h expected %h", sub, exp_sub); else n_pass++;
        @(negedge clk_pixel);
        reset_n = 1'b1;
        repeat (LEN + 4) @(negedge clk_pixel);
        frame_pulse(slot);
        n_checks++;
        if (pkt_valid !== slot) $display("[TB] FAIL midreset_emit: pkt_valid=%b expected %b", pkt_valid, slot); else n_pass++;
        n_checks++;
        if (sub !== exp_sub || cfg_ready !== 1'b1) $display("[TB] FAIL midreset_discard: sub=%h cfg_ready=%b expected %h/1", sub, cfg_ready, exp_sub); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        cfg_valid   = 1'b0;
        cfg_pb      = '0;
        frame_start = 1'b0;
        pkt_ready   = 1'b0;
        @(negedge clk_pixel);
        test_reset();
        test_audio();
        test_mask();
        test_repeat();
        test_overrun();
        test_commit_hold();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
